// File: rtl/pulser_trigger_sequencer.sv
// Pulser trigger burst sequencer: fires 2^AVG_LOG2 triggers, averages the returned propagation counts.
// Optional min/max tracking of accepted samples is built when PULSER_MINMAX_EN is defined.
module pulser_trigger_sequencer #(
    parameter int          CNT_W      = 16,
    parameter int          TRIG_WIDTH = 8,
    parameter logic [15:0] TIMEOUT    = 16'hFFFF,
    parameter int          AVG_LOG2   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [15:0]      Period,
    input  logic             Pulse_Measurement_Done,
    input  logic [CNT_W-1:0] Pulse_Propagation_Counter,
    input  logic             Pulser_IC_Error,
    output logic             Pulser_Trigger_Request,
    output logic             Busy,
    output logic             Result_Valid,
    output logic [CNT_W-1:0] Result_Avg,
    output logic             Timeout_Error,
    output logic             IC_Error,
    output logic [CNT_W-1:0] Result_Min,
    output logic [CNT_W-1:0] Result_Max
);

    localparam int          ACC_W      = CNT_W + AVG_LOG2;
    localparam logic [4:0]  SHOTS_N    = 5'(1 << AVG_LOG2);
    localparam logic [15:0] TW_LAST    = 16'(TRIG_WIDTH - 1);
    localparam logic [15:0] MIN_PERIOD = 16'(TRIG_WIDTH + 4);
    localparam logic [15:0] TMO_LAST   = TIMEOUT - 16'd1;

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_GAP, S_REPORT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_done_q;
    logic [15:0]        r_period_cnt;
    logic [15:0]        r_tmo_cnt;
    logic [15:0]        r_eff_period;
    logic [4:0]         r_shots;
    logic               r_sampled;
    logic [ACC_W-1:0]   r_acc;
    logic               r_result_valid;
    logic [CNT_W-1:0]   r_result_avg;
    logic               r_timeout_err;
    logic               r_ic_err;

    logic               w_done_rise;
    logic               w_tmo_hit;
    logic               w_start;
    logic               w_accept;
    logic               w_set_tmo;
    logic               w_set_ic;
    logic               w_report;
    logic               w_enter_trig;
    logic [ACC_W-1:0]   w_avg;

    assign w_done_rise = Pulse_Measurement_Done & ~r_done_q;
    // Fires on the edge that would make the counter equal TIMEOUT.
    assign w_tmo_hit   = (r_tmo_cnt >= TMO_LAST);
    assign w_avg       = r_acc >> AVG_LOG2;

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_accept = 1'b0;
        w_set_tmo = 1'b0;
        w_set_ic = 1'b0;
        w_report = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Pulser_IC_Error) begin
                    w_set_ic = 1'b1;
                end else if (Start) begin
                    w_start = 1'b1;
                    w_next  = S_TRIG;
                end
            end
            S_TRIG: begin
                if (Pulser_IC_Error) begin
                    w_set_ic = 1'b1;
                    w_next   = S_IDLE;
                end else begin
                    w_accept = w_done_rise & ~r_sampled;
                    if (w_tmo_hit && !w_accept) begin
                        w_set_tmo = 1'b1;
                        w_next    = S_IDLE;
                    end else if (r_period_cnt >= TW_LAST) begin
                        w_next = (r_sampled || w_accept) ? S_GAP : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (Pulser_IC_Error) begin
                    w_set_ic = 1'b1;
                    w_next   = S_IDLE;
                end else if (w_done_rise) begin
                    w_accept = 1'b1;
                    w_next   = S_GAP;
                end else if (w_tmo_hit) begin
                    w_set_tmo = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_GAP: begin
                if (Pulser_IC_Error) begin
                    w_set_ic = 1'b1;
                    w_next   = S_IDLE;
                end else if (r_period_cnt >= r_eff_period - 16'd1) begin
                    if (r_shots == SHOTS_N) begin
                        w_report = 1'b1;
                        w_next   = S_REPORT;
                    end else begin
                        w_next = S_TRIG;
                    end
                end
            end
            S_REPORT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_enter_trig = (w_next == S_TRIG) && (r_state != S_TRIG);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_done_q       <= 1'b0;
            r_period_cnt   <= '0;
            r_tmo_cnt      <= '0;
            r_eff_period   <= '0;
            r_shots        <= '0;
            r_sampled      <= 1'b0;
            r_acc          <= '0;
            r_result_valid <= 1'b0;
            r_result_avg   <= '0;
            r_timeout_err  <= 1'b0;
            r_ic_err       <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_done_q <= Pulse_Measurement_Done;
            if (w_enter_trig) begin
                r_period_cnt <= '0;
                r_tmo_cnt    <= '0;
                r_sampled    <= 1'b0;
            end else begin
                if (r_period_cnt != 16'hFFFF) r_period_cnt <= r_period_cnt + 16'd1;
                if (r_tmo_cnt != 16'hFFFF)    r_tmo_cnt    <= r_tmo_cnt + 16'd1;
                if (w_accept)                 r_sampled    <= 1'b1;
            end
            if (w_start) begin
                r_eff_period  <= (Period >= MIN_PERIOD) ? Period : MIN_PERIOD;
                r_acc         <= '0;
                r_shots       <= '0;
                r_timeout_err <= 1'b0;
                r_ic_err      <= 1'b0;
            end
            if (w_accept) begin
                r_acc   <= r_acc + ACC_W'(Pulse_Propagation_Counter);
                r_shots <= r_shots + 5'd1;
            end
            if (w_set_tmo) r_timeout_err <= 1'b1;
            if (w_set_ic)  r_ic_err      <= 1'b1;
            r_result_valid <= w_report;
            if (w_report) r_result_avg <= w_avg[CNT_W-1:0];
        end
    end

`ifdef PULSER_MINMAX_EN
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] r_result_min;
    logic [CNT_W-1:0] r_result_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_min        <= '0;
            r_max        <= '0;
            r_result_min <= '0;
            r_result_max <= '0;
        end else begin
            if (w_start) begin
                r_min <= '1;
                r_max <= '0;
            end
            if (w_accept) begin
                if (Pulse_Propagation_Counter < r_min) r_min <= Pulse_Propagation_Counter;
                if (Pulse_Propagation_Counter > r_max) r_max <= Pulse_Propagation_Counter;
            end
            if (w_report) begin
                r_result_min <= r_min;
                r_result_max <= r_max;
            end
        end
    end

    assign Result_Min = r_result_min;
    assign Result_Max = r_result_max;
`else
    assign Result_Min = '0;
    assign Result_Max = '0;
`endif

    assign Pulser_Trigger_Request = (r_state == S_TRIG) && !Pulser_IC_Error;
    assign Busy                   = (r_state != S_IDLE);
    assign Result_Valid           = r_result_valid;
    assign Result_Avg             = r_result_avg;
    assign Timeout_Error          = r_timeout_err;
    assign IC_Error               = r_ic_err;

endmodule

// File: tb/tb_pulser_trigger_sequencer.sv
// Directed bench for pulser_trigger_sequencer (TRIG_WIDTH=8, TIMEOUT=300, AVG_LOG2=2).
module tb_pulser_trigger_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [15:0] Period;
    logic        Done;
    logic [15:0] Cnt;
    logic        IcErr;
    logic        Req;
    logic        Busy;
    logic        Valid;
    logic [15:0] Avg;
    logic        TmoErr;
    logic        IcFlag;
    logic [15:0] RMin;
    logic [15:0] RMax;

    int checks = 0;
    int errors = 0;
    logic [15:0] cnt_tbl [4];

    always #5 clk = ~clk;

    pulser_trigger_sequencer #(
        .CNT_W(16), .TRIG_WIDTH(8), .TIMEOUT(16'd300), .AVG_LOG2(2)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .Start                    (Start),
        .Period                   (Period),
        .Pulse_Measurement_Done   (Done),
        .Pulse_Propagation_Counter(Cnt),
        .Pulser_IC_Error          (IcErr),
        .Pulser_Trigger_Request   (Req),
        .Busy                     (Busy),
        .Result_Valid             (Valid),
        .Result_Avg               (Avg),
        .Timeout_Error            (TmoErr),
        .IC_Error                 (IcFlag),
        .Result_Min               (RMin),
        .Result_Max               (RMax)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Measurement-side model: Done high for 3 cycles starting doff cycles after each trigger.
    task automatic drive_done(input int c, input int eff, input int doff, input int nresp);
        int k;
        int off;
        k   = (c - 1) / eff;
        off = (c - 1) % eff;
        if (k < nresp && off >= doff && off < doff + 3) begin
            Done = 1'b1;
            Cnt  = cnt_tbl[k];
        end else begin
            Done = 1'b0;
            Cnt  = 16'hFFFF;
        end
    endtask

    task automatic burst(input logic [15:0] per, input int eff, input int doff, input bit hold,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] cc,
                         input logic [15:0] d, input logic [15:0] exp_avg,
                         input logic [15:0] exp_min, input logic [15:0] exp_max, input string tag);
        int   bad_req;
        int   bad_busy;
        int   bad_valid;
        logic exp_req;
        logic exp_busy;
        logic exp_valid;
        bad_req   = 0;
        bad_busy  = 0;
        bad_valid = 0;
        cnt_tbl   = '{a, b, cc, d};
        Period    = per;
        if (hold) begin
            Done = 1'b1;
            Cnt  = 16'hFFFF;
            tick();
            tick();
        end
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c <= 4 * eff + 2; c++) begin
            exp_req   = (c <= 4 * eff) && (((c - 1) % eff) < 8);
            exp_busy  = (c <= 4 * eff + 1);
            exp_valid = (c == 4 * eff + 1);
            if (Req !== exp_req)     bad_req++;
            if (Busy !== exp_busy)   bad_busy++;
            if (Valid !== exp_valid) bad_valid++;
            if (c == 1) begin
                chk({tag, "_tmo_clr"}, TmoErr, 1'b0);
                chk({tag, "_ic_clr"}, IcFlag, 1'b0);
            end
            drive_done(c, eff, doff, 4);
            if (hold && c < 5) Done = 1'b1;
            tick();
        end
        chk({tag, "_req_pattern_errs"}, bad_req, 0);
        chk({tag, "_busy_errs"}, bad_busy, 0);
        chk({tag, "_valid_errs"}, bad_valid, 0);
        chk({tag, "_avg"}, Avg, exp_avg);
`ifdef PULSER_MINMAX_EN
        chk({tag, "_min"}, RMin, exp_min);
        chk({tag, "_max"}, RMax, exp_max);
`else
        chk({tag, "_min"}, RMin, 16'd0);
        chk({tag, "_max"}, RMax, 16'd0);
`endif
    endtask

    initial begin
        int seen_valid;
        reset  = 1'b1;
        Start  = 1'b0;
        Period = 16'd0;
        Done   = 1'b0;
        Cnt    = 16'd0;
        IcErr  = 1'b0;
        tick();
        tick();
        chk("rst_req", Req, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_valid", Valid, 1'b0);
        chk("rst_avg", Avg, 16'd0);
        chk("rst_tmo", TmoErr, 1'b0);
        chk("rst_ic", IcFlag, 1'b0);
        reset = 1'b0;
        tick();

        // Nominal burst: period 200, Done 100 cycles after each trigger.
        burst(16'd200, 200, 100, 1'b0, 16'd100, 16'd102, 16'd98, 16'd104,
              16'd101, 16'd98, 16'd104, "nominal");

        // Period below TRIG_WIDTH+4 is stretched to 12.
        burst(16'd5, 12, 2, 1'b0, 16'd10, 16'd20, 16'd30, 16'd41,
              16'd25, 16'd10, 16'd41, "short_period");

        // Done already high at Start must not count as a sample.
        burst(16'd200, 200, 100, 1'b1, 16'd50, 16'd60, 16'd70, 16'd80,
              16'd65, 16'd50, 16'd80, "held_done");

        // Timeout on shot 3 (triggered at cycle 401).
        cnt_tbl    = '{16'd11, 16'd12, 16'd13, 16'd14};
        Period     = 16'd200;
        seen_valid = 0;
        Start      = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c <= 701; c++) begin
            if (Valid) seen_valid++;
            if (c == 401) chk("tmo_shot3_req", Req, 1'b1);
            if (c == 700) begin
                chk("tmo_pre_busy", Busy, 1'b1);
                chk("tmo_pre_flag", TmoErr, 1'b0);
            end
            if (c == 701) begin
                chk("tmo_flag", TmoErr, 1'b1);
                chk("tmo_busy", Busy, 1'b0);
                chk("tmo_req", Req, 1'b0);
            end
            drive_done(c, 200, 100, 2);
            tick();
        end
        chk("tmo_no_valid", seen_valid, 0);
        chk("tmo_avg_kept", Avg, 16'd65);

        // Next Start clears the timeout flag.
        burst(16'd20, 20, 10, 1'b0, 16'd1, 16'd2, 16'd3, 16'd6,
              16'd3, 16'd1, 16'd6, "after_tmo");

        // IC error pulsed in WAIT of shot 3.
        cnt_tbl    = '{16'd5, 16'd5, 16'd5, 16'd5};
        Period     = 16'd200;
        seen_valid = 0;
        Start      = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c <= 452; c++) begin
            if (Valid) seen_valid++;
            if (c == 451) chk("ic_pre_flag", IcFlag, 1'b0);
            if (c == 452) begin
                chk("ic_flag", IcFlag, 1'b1);
                chk("ic_busy", Busy, 1'b0);
                chk("ic_req", Req, 1'b0);
            end
            drive_done(c, 200, 100, 4);
            IcErr = (c == 451);
            if (c < 452) tick();
        end
        chk("ic_no_valid", seen_valid, 0);
        IcErr = 1'b1;
        Start = 1'b1;
        tick();
        chk("ic_blocks_start_busy", Busy, 1'b0);
        chk("ic_blocks_start_req", Req, 1'b0);
        chk("ic_blocks_start_flag", IcFlag, 1'b1);
        Start = 1'b0;
        IcErr = 1'b0;
        tick();

        // IC error during TRIG gates Request in the same cycle.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("ictrig_req_on", Req, 1'b1);
        chk("ictrig_flag_clr", IcFlag, 1'b0);
        tick();
        tick();
        IcErr = 1'b1;
        #1;
        chk("ictrig_req_gated", Req, 1'b0);
        tick();
        IcErr = 1'b0;
        chk("ictrig_busy", Busy, 1'b0);
        chk("ictrig_flag", IcFlag, 1'b1);
        tick();

        // Fill the result with a known value, then reset mid-GAP.
        burst(16'd20, 20, 10, 1'b0, 16'd4, 16'd8, 16'd12, 16'd16,
              16'd10, 16'd4, 16'd16, "pre_reset");
        cnt_tbl = '{16'd7, 16'd7, 16'd7, 16'd7};
        Period  = 16'd200;
        Start   = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c < 150; c++) begin
            drive_done(c, 200, 100, 4);
            tick();
        end
        chk("gap_busy_before_rst", Busy, 1'b1);
        Done  = 1'b0;
        reset = 1'b1;
        tick();
        chk("midrst_busy", Busy, 1'b0);
        chk("midrst_req", Req, 1'b0);
        chk("midrst_avg", Avg, 16'd0);
        chk("midrst_valid", Valid, 1'b0);
        reset = 1'b0;
        tick();
        burst(16'd200, 200, 100, 1'b0, 16'd100, 16'd102, 16'd98, 16'd104,
              16'd101, 16'd98, 16'd104, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
